// File: rtl/demux_1_8_deser.sv
// demux_1_8_deser: serial-to-parallel 1:8 demultiplexer with a valid/ready
// output register and a sticky overrun flag.
`default_nettype none

module demux_1_8_deser #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  input  logic       out_ready,
  input  logic       ovr_clr,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [2:0] sel,
  output logic       overrun
);

  localparam logic [2:0] SLOT0_POS = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

  logic [2:0] sel_q, sel_d;
  logic [7:0] asm_q, asm_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       overrun_q, overrun_d;

  logic [2:0] slot_pos;
  logic       complete;
  logic       ovr_set;
  logic [7:0] word;

  always_comb begin
    slot_pos    = (MSB_FIRST != 0) ? (3'd7 - sel_q) : sel_q;
    // A sync on the would-be 8th bit wins: the word never completes.
    complete    = din_valid && !sync && (sel_q == 3'd7);
    word        = asm_q;
    word[slot_pos] = din;

    sel_d       = sel_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovr_set     = 1'b0;

    if (sync) begin
      asm_d = 8'h00;
      if (din_valid) begin
        asm_d[SLOT0_POS] = din;
        sel_d            = 3'd1;
      end else begin
        sel_d = 3'd0;
      end
    end else if (din_valid) begin
      sel_d = sel_q + 3'd1;
      asm_d = complete ? 8'h00 : word;
    end

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_d       = word;
        out_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 3'd0;
      asm_q       <= 8'h00;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_1_8_deser.sv
// tb_demux_1_8_deser: scoreboard bench driving LSB-first and MSB-first
// instances with a shared stream, checked against a bit-list reference model.
`default_nettype none

module tb_demux_1_8_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0, din_valid = 1'b0, sync = 1'b0;
  logic       out_ready = 1'b0, ovr_clr = 1'b0;
  logic [7:0] out_l, out_m;
  logic       valid_l, valid_m, ovr_l, ovr_m;
  logic [2:0] sel_l, sel_m;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  // Reference model state: bits received for the word in progress, words
  // awaiting consumption, output-register occupancy and overrun.
  bit         bits[$];
  logic [7:0] ql[$];
  logic [7:0] qm[$];
  logic       m_full = 1'b0;
  logic       m_ovr  = 1'b0;

  always #5 clk = ~clk;

  demux_1_8_deser #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .out_ready(out_ready), .ovr_clr(ovr_clr), .out(out_l), .out_valid(valid_l),
    .sel(sel_l), .overrun(ovr_l)
  );

  demux_1_8_deser #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .out_ready(out_ready), .ovr_clr(ovr_clr), .out(out_m), .out_valid(valid_m),
    .sel(sel_m), .overrun(ovr_m)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    bits.delete();
    ql.delete();
    qm.delete();
    m_full = 1'b0;
    m_ovr  = 1'b0;
  endfunction

  // Applies the sampled inputs of one clock edge to the model.
  function automatic void model_step();
    logic       completed = 1'b0;
    logic       set_ovr = 1'b0;
    logic [7:0] wl = 8'h00;
    logic [7:0] wm = 8'h00;
    if (sync) begin
      bits.delete();
      if (din_valid) bits.push_back(din);
    end else if (din_valid) begin
      bits.push_back(din);
      if (bits.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          wl[i]     = bits[i];
          wm[7 - i] = bits[i];
        end
        bits.delete();
        completed = 1'b1;
      end
    end
    if (completed) begin
      if (!m_full || out_ready) begin
        ql.push_back(wl);
        qm.push_back(wm);
        m_full = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    m_ovr = set_ovr | (m_ovr & ~ovr_clr);
  endfunction

  // Monitor: compares every cycle; pops a word when the consumer takes it.
  always @(negedge clk) begin
    if (!done) begin
      chk("sel_lsb", {29'd0, sel_l}, bits.size());
      chk("sel_msb", {29'd0, sel_m}, bits.size());
      chk("valid_lsb", {31'd0, valid_l}, {31'd0, m_full});
      chk("valid_msb", {31'd0, valid_m}, {31'd0, m_full});
      chk("ovr_lsb", {31'd0, ovr_l}, {31'd0, m_ovr});
      chk("ovr_msb", {31'd0, ovr_m}, {31'd0, m_ovr});
      if (m_full) begin
        chk("sb_nonempty", {31'd0, (ql.size() != 0)}, 32'd1);
        if (ql.size() != 0) begin
          chk("word_lsb", {24'd0, out_l}, {24'd0, ql[0]});
          chk("word_msb", {24'd0, out_m}, {24'd0, qm[0]});
          if (out_ready) begin
            void'(ql.pop_front());
            void'(qm.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic d, input logic s,
                     input logic r, input logic c);
    din_valid = v;
    din       = d;
    sync      = s;
    out_ready = r;
    ovr_clr   = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input int maxgap,
                           input logic r, input logic clr_last);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(maxgap, 0)) cyc(1'b0, 1'($urandom % 2), 1'b0, r, 1'b0);
      cyc(1'b1, w[i], 1'b0, r, (i == 7) ? clr_last : 1'b0);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_out"}, {16'd0, out_l, out_m}, 32'd0);
    chk({tag, "_valid"}, {30'd0, valid_l, valid_m}, 32'd0);
    chk({tag, "_sel"}, {26'd0, sel_l, sel_m}, 32'd0);
    chk({tag, "_ovr"}, {30'd0, ovr_l, ovr_m}, 32'd0);
  endtask

  initial begin
    logic [7:0] expw;
    logic       b;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 rst_n = 1'b1;

    // LSB-first 1,0,1,1,0,0,1,0 -> 4D; MSB-first -> B2
    send_word(8'h4D, 0, 1'b1, 1'b0);
    chk("t1_lsb", {24'd0, out_l}, 32'h4D);
    chk("t1_msb", {24'd0, out_m}, 32'hB2);
    chk("t1_valid", {31'd0, valid_l}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_drop", {31'd0, valid_l}, 32'd0);
    chk("t1_sel0", {29'd0, sel_l}, 32'd0);

    // Back-to-back words with gaps
    send_word(8'hA5, 3, 1'b1, 1'b0);
    chk("t3_a5", {24'd0, out_l}, 32'hA5);
    send_word(8'h3C, 3, 1'b1, 1'b0);
    chk("t3_3c", {24'd0, out_l}, 32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun with stalled consumer
    send_word(8'h11, 0, 1'b0, 1'b0);
    send_word(8'h22, 0, 1'b0, 1'b0);
    chk("t4_hold", {24'd0, out_l}, 32'h11);
    chk("t4_ovr", {31'd0, ovr_l}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_clr", {31'd0, ovr_l}, 32'd0);
    send_word(8'h33, 0, 1'b0, 1'b1);
    chk("t4_setwins", {31'd0, ovr_l}, 32'd1);
    chk("t4_hold2", {24'd0, out_l}, 32'h11);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sync after five bits
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom % 2), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expw = 8'h01;
    for (int i = 1; i < 8; i++) begin
      b       = 1'($urandom % 2);
      expw[i] = b;
      cyc(1'b1, b, 1'b0, 1'b1, 1'b0);
    end
    chk("t5_word", {24'd0, out_l}, {24'd0, expw});
    chk("t5_valid", {31'd0, valid_l}, 32'd1);
    chk("t5_ovr", {31'd0, ovr_l}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word with a held output word
    send_word(8'h5A, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom % 2), 1'b0, 1'b0, 1'b0);
    chk("t6_sel4", {29'd0, sel_l}, 32'd4);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_zero("t6_async");
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_word(8'h96, 1, 1'b1, 1'b0);
    chk("t6_lsb", {24'd0, out_l}, 32'h96);
    chk("t6_msb", {24'd0, out_m}, 32'h69);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 23 == 0),
          1'($urandom % 3 != 0), 1'($urandom % 17 == 0));
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", ql.size(), 32'd0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_1_8_deser.md
Name: demux_1_8_deser

Overview:
- Serial-to-parallel 1-to-8 demultiplexer: the receive-side counterpart of the 8:1 bit-select multiplexer.
- Steers a serial bit stream, one bit per valid cycle, into 8 slot positions using an internal 3-bit slot counter.
- Presents each completed 8-bit word through a valid/ready output register with overrun detection.
- Sits downstream of any serializer built on the 8:1 mux and recovers its parallel word.

Parameters:
- MSB_FIRST, 0: 0 means the first bit of a word lands in out[0]; 1 means it lands in out[7].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din is sampled this cycle
- sync  input  1  word-alignment strobe; the current cycle starts a new word at slot 0
- out_ready  input  1  consumer accepts out this cycle
- ovr_clr  input  1  clears the sticky overrun flag
- out  output  8  last completed word (registered)
- out_valid  output  1  out holds an unconsumed word
- sel  output  3  slot index the next valid bit will occupy
- overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset: rst_n low asynchronously forces sel=0, the internal assembly register asm=0, out=8'h00, out_valid=0, overrun=0. Reset applied mid-word discards the partial word; the first valid bit after release goes to slot 0.
- Slot mapping: position p = sel when MSB_FIRST=0; p = 7-sel when MSB_FIRST=1.
- din_valid=1, sync=0:
  - Writes asm[p]=din.
  - sel increments modulo 8; 7 wraps to 0.
- din_valid=0, sync=0: sel and asm hold; din is ignored.
- sync=1, din_valid=1:
  - asm is cleared, then din is written at slot 0's position, and sel becomes 1.
  - The partial word is discarded; no overrun is flagged.
- sync=1, din_valid=0: sel becomes 0 and asm is cleared.
- Word completion:
  - Occurs when din_valid=1, sync=0 and sel=7.
  - The completed word is asm with the current din merged at slot 7's position.
  - asm clears for the next word.
- Output register, evaluated each edge:
  - Completion with (out_valid=0 or out_ready=1): out loads the word and out_valid=1 next cycle. Latency is 1 cycle from the 8th valid bit's edge to out_valid high.
  - Completion with out_valid=1 and out_ready=0: the new word is dropped, out is unchanged, and overrun is set.
  - No completion with out_valid=1 and out_ready=1: out_valid=0 next cycle; out retains its value.
  - out_ready while out_valid=0 has no effect.
- overrun:
  - Sticky; cleared only by ovr_clr or reset.
  - A set event in the same cycle as ovr_clr leaves overrun=1 (set wins).
- sel is a direct view of the slot counter and is not gated by out_valid. Input is never back-pressured.
- A single-bit sync on the same cycle as a would-be completion (sel=7) is treated as a sync: the word does not complete.

Test Plan:
- Reset then 8 valid bits 1,0,1,1,0,0,1,0 with MSB_FIRST=0 and out_ready=1 -> out=8'h4D, out_valid high exactly 1 cycle after the 8th bit, then low the next cycle; sel returns to 0.
- Same stream with MSB_FIRST=1 -> out=8'hB2.
- Back-to-back words 8'hA5 then 8'h3C, with din_valid gaps of 0 to 3 cycles between bits -> two words delivered in order; sel holds during gaps; out_valid pulses twice.
- out_ready held 0 across two complete words (8'h11 then 8'h22) -> out stays 8'h11, overrun=1.
  - Then ovr_clr=1 -> overrun=0.
  - Then ovr_clr coincident with a third dropped word -> overrun stays 1.
- sync with din_valid=1 after 5 bits, then 7 further valid bits -> the partial word is discarded and the new word (sync bit in slot 0) completes on the 8th bit counted from sync; overrun=0.
- rst_n asserted asynchronously mid-word (sel=4, out_valid=1) -> all outputs are 0 immediately, before the next clk edge; the next 8 valid bits form a correct word.
